// File: rtl/oam_dma_controller.sv
// Sprite (OAM) DMA bus initiator: halts the CPU and copies one page to the OAM data port.
// Optional registered debug word enabled with OAM_DMA_DEBUG_EN.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_COUNT    = 256
) (
  input  logic        dma_clk_in,
  input  logic        dma_reset_in,
  input  logic        dma_cpu_write_in,
  input  logic [15:0] dma_cpu_address_in,
  input  logic [7:0]  dma_cpu_data_in,
  output logic        dma_halt_out,
  output logic        dma_read_out,
  output logic        dma_write_out,
  output logic [15:0] dma_address_out,
  input  logic [7:0]  dma_data_in,
  output logic [7:0]  dma_data_out,
  output logic [15:0] debug_out
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  localparam logic [7:0] LAST_INDEX = 8'(XFER_COUNT - 1);

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic        parity_q;
  logic        halt_q, halt_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [15:0] address_q, address_d;

  always_ff @(posedge dma_clk_in) begin
    if (dma_reset_in) begin
      state_q   <= IDLE;
      page_q    <= '0;
      index_q   <= '0;
      parity_q  <= 1'b0;
      halt_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      address_q <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      index_q   <= index_d;
      parity_q  <= ~parity_q;
      halt_q    <= halt_d;
      read_q    <= read_d;
      write_q   <= write_d;
      address_q <= address_d;
    end
  end

  // Outputs are decoded from the next state so they are registered yet line up with the state.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (dma_cpu_write_in && (dma_cpu_address_in == DMA_REG_ADDR)) begin
          page_d  = dma_cpu_data_in;
          index_d = '0;
          state_d = HALT;
        end
      end
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        if (index_q == LAST_INDEX) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    halt_d    = (state_d != IDLE);
    read_d    = (state_d == READ);
    write_d   = (state_d == WRITE);
    address_d = '0;
    if (state_d == READ) begin
      address_d = {page_d, index_d};
    end else if (state_d == WRITE) begin
      address_d = OAM_DATA_ADDR;
    end
  end

  // Read data arrives one cycle after the read strobe, i.e. during WRITE, and passes straight through.
  always_comb begin
    dma_data_out = '0;
    if (write_q) begin
      dma_data_out = dma_data_in;
    end
  end

  assign dma_halt_out    = halt_q;
  assign dma_read_out    = read_q;
  assign dma_write_out   = write_q;
  assign dma_address_out = address_q;

`ifdef OAM_DMA_DEBUG_EN
  logic [15:0] debug_q;

  always_ff @(posedge dma_clk_in) begin
    if (dma_reset_in) begin
      debug_q <= '0;
    end else begin
      debug_q <= {state_q, parity_q, 4'b0000, index_q};
    end
  end

  assign debug_out = debug_q;
`else
  assign debug_out = '0;
`endif

endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomized self-checking bench for oam_dma_controller against a transfer-schedule model.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        dma_reset_in = 1'b1;
  logic        dma_cpu_write_in = 1'b0;
  logic [15:0] dma_cpu_address_in = '0;
  logic [7:0]  dma_cpu_data_in = '0;
  logic        dma_halt_out;
  logic        dma_read_out;
  logic        dma_write_out;
  logic [15:0] dma_address_out;
  logic [7:0]  dma_data_in = '0;
  logic [7:0]  dma_data_out;
  logic [15:0] debug_out;

  always #5 clk = ~clk;

  oam_dma_controller #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004),
    .XFER_COUNT   (256)
  ) dut (
    .dma_clk_in        (clk),
    .dma_reset_in      (dma_reset_in),
    .dma_cpu_write_in  (dma_cpu_write_in),
    .dma_cpu_address_in(dma_cpu_address_in),
    .dma_cpu_data_in   (dma_cpu_data_in),
    .dma_halt_out      (dma_halt_out),
    .dma_read_out      (dma_read_out),
    .dma_write_out     (dma_write_out),
    .dma_address_out   (dma_address_out),
    .dma_data_in       (dma_data_in),
    .dma_data_out      (dma_data_out),
    .debug_out         (debug_out)
  );

  logic [7:0] mem [0:65535];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Transfer model: a transfer is a schedule of halted cycles numbered from the trigger.
  bit         m_active = 1'b0;
  bit         m_align  = 1'b0;
  bit         m_parity = 1'b0;
  int         m_k      = 0;
  int         m_idle_run = 0;
  logic [7:0] m_page   = '0;

  int          halt_cnt, read_cnt, write_cnt, zero_acc;
  logic [15:0] first_rd, last_rd;
  logic [7:0]  first_wr_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_stats();
    halt_cnt = 0; read_cnt = 0; write_cnt = 0; zero_acc = 0;
    first_rd = '0; last_rd = '0; first_wr_data = '0;
  endtask

  // Byte slot j within the transfer: even j is the read of byte j/2, odd j its write.
  function automatic int cur_slot();
    if (!m_active || m_k < 1 + int'(m_align)) return -1;
    return m_k - 1 - int'(m_align);
  endfunction

  task automatic step(input bit rst, input bit wr, input logic [15:0] addr, input logic [7:0] data);
    bit          rd_prev;
    logic [15:0] a_prev;
    bit          e_halt, e_rd, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    int          j;
    dma_reset_in = rst;
    dma_cpu_write_in = wr;
    dma_cpu_address_in = addr;
    dma_cpu_data_in = data;
    rd_prev = dma_read_out;
    a_prev  = dma_address_out;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0; m_parity = 1'b0; m_k = 0;
    end else begin
      m_parity = ~m_parity;
      if (m_active) begin
        m_k++;
        if (m_k == 513 + int'(m_align)) m_active = 1'b0;
      end else if (wr && addr == 16'h4014) begin
        m_active = 1'b1; m_k = 0; m_page = data; m_align = (m_parity == 1'b0);
      end
    end
    m_idle_run = m_active ? 0 : m_idle_run + 1;
    #1;
    if (rd_prev) dma_data_in = mem[a_prev];
    #1;
    e_halt = m_active; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
    j = cur_slot();
    if (j >= 0) begin
      if (j % 2 == 0) begin
        e_rd = 1'b1; e_addr = {m_page, 8'(j / 2)};
      end else begin
        e_wr = 1'b1; e_addr = 16'h2004; e_data = mem[{m_page, 8'(j / 2)}];
      end
    end
    check_eq("halt", 32'(dma_halt_out), 32'(e_halt));
    check_eq("read", 32'(dma_read_out), 32'(e_rd));
    check_eq("write", 32'(dma_write_out), 32'(e_wr));
    check_eq("address", 32'(dma_address_out), 32'(e_addr));
    check_eq("data_out", 32'(dma_data_out), 32'(e_data));
    if (dma_read_out) check_eq("read_parity", 32'(m_parity), 32'd0);
`ifdef OAM_DMA_DEBUG_EN
    if (m_idle_run >= 2) check_eq("debug_state", 32'(debug_out[15:13]), 32'd0);
`else
    check_eq("debug", 32'(debug_out), 32'd0);
`endif
    if (dma_halt_out) halt_cnt++;
    if (dma_read_out) begin
      if (read_cnt == 0) first_rd = dma_address_out;
      last_rd = dma_address_out;
      read_cnt++;
    end
    if (dma_write_out) begin
      if (write_cnt == 0) first_wr_data = dma_data_out;
      write_cnt++;
    end
    if ((dma_read_out || dma_write_out) && dma_address_out == 16'h0000) zero_acc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic noise(input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      step(1'b0, 1'($urandom), a, 8'($urandom));
    end
  endtask

  // Advance until the model parity matches, so the next edge's HALT lands on a chosen parity.
  task automatic wait_parity(input bit p);
    if (m_parity != p) idle(1);
  endtask

  task automatic finish_xfer();
    for (int i = 0; i < 600 && m_active; i++) idle(1);
    check_eq("xfer_done", 32'(m_active), 32'd0);
  endtask

  task automatic trigger(input logic [7:0] page);
    clear_stats();
    step(1'b0, 1'b1, 16'h4014, page);
  endtask

  initial begin
    logic [7:0] pg;
    bit         al;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0200] = 8'hA5;

    step(1'b1, 1'b0, 16'h0000, 8'h00);
    step(1'b1, 1'b1, 16'h4014, 8'h09);
    idle(3);

    // Test 1: HALT on parity 0 -> ALIGN inserted
    wait_parity(1'b1);
    trigger(8'h02);
    finish_xfer();
    check_eq("t1_halt_cnt", 32'(halt_cnt), 32'd514);
    check_eq("t1_reads", 32'(read_cnt), 32'd256);
    check_eq("t1_writes", 32'(write_cnt), 32'd256);
    check_eq("t1_first_rd", 32'(first_rd), 32'h0200);
    check_eq("t1_last_rd", 32'(last_rd), 32'h02FF);
    check_eq("t1_first_data", 32'(first_wr_data), 32'hA5);
    noise(5);

    // Test 2: HALT on parity 1 -> no ALIGN
    wait_parity(1'b0);
    trigger(8'($urandom));
    finish_xfer();
    check_eq("t2_halt_cnt", 32'(halt_cnt), 32'd513);
    idle(2);

    // Test 3: last page, no wrap to $0000
    trigger(8'hFF);
    finish_xfer();
    check_eq("t3_first_rd", 32'(first_rd), 32'hFF00);
    check_eq("t3_last_rd", 32'(last_rd), 32'hFFFF);
    check_eq("t3_zero_acc", 32'(zero_acc), 32'd0);
    idle(1);
    check_eq("t3_halt_after", 32'(dma_halt_out), 32'd0);

    // Test 4: retrigger attempt at byte 10 is ignored
    trigger(8'h03);
    al = m_align;
    for (int i = 0; i < 100 && cur_slot() != 20; i++) idle(1);
    check_eq("t4_at_byte10", 32'(cur_slot()), 32'd20);
    step(1'b0, 1'b1, 16'h4014, 8'h05);
    finish_xfer();
    check_eq("t4_halt_cnt", 32'(halt_cnt), 32'(513 + int'(al)));
    check_eq("t4_reads", 32'(read_cnt), 32'd256);
    check_eq("t4_last_rd", 32'(last_rd), 32'h03FF);

    // Test 5: reset during the WRITE of byte 100, then a fresh transfer
    pg = 8'($urandom_range(1, 254));
    trigger(pg);
    for (int i = 0; i < 400 && cur_slot() != 201; i++) idle(1);
    check_eq("t5_at_write100", 32'(dma_write_out && cur_slot() == 201), 32'd1);
    step(1'b1, 1'b0, 16'h0000, 8'h00);
    check_eq("t5_reset_halt", 32'(dma_halt_out), 32'd0);
    idle(4);
    trigger(pg);
    finish_xfer();
    check_eq("t5_first_rd", 32'(first_rd), 32'({pg, 8'h00}));
    check_eq("t5_reads", 32'(read_cnt), 32'd256);

    // Test 6: non-trigger register traffic
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 16'h4015, 8'h07);
      step(1'b0, 1'b0, 16'h4014, 8'h07);
    end
    check_eq("t6_halt_cnt", 32'(halt_cnt), 32'd0);
    check_eq("t6_strobes", 32'(read_cnt + write_cnt), 32'd0);

    // Random transfers with bus noise and stray triggers
    for (int t = 0; t < 4; t++) begin
      noise($urandom_range(1, 6));
      trigger(8'($urandom));
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 16'h4014, 8'($urandom));
        else noise(1);
      end
      finish_xfer();
      check_eq("rnd_halt_cnt", 32'(halt_cnt), 32'(513 + int'(m_align)));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Bus initiator for sprite DMA: a CPU write to the DMA register (page number) starts a transfer.
- Halts the CPU and copies 256 bytes from page:$00..page:$FF onto the shared bus, writing each byte to the OAM data port.
- Sits between the CPU bus decode and the RAM/PPU responders; it drives the read strobes into ram_controller and the write strobes into the PPU.
- Mirrors NES $4014 timing: 513 or 514 halted cycles, depending on cycle parity.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers the transfer
- OAM_DATA_ADDR, 16'h2004, destination address for every write
- XFER_COUNT, 256, bytes per transfer (power of two, at most 256)

Ports:
- dma_clk_in  input  1  system clock; all logic on rising edge
- dma_reset_in  input  1  synchronous, active-high reset
- dma_cpu_write_in  input  1  CPU write strobe
- dma_cpu_address_in  input  16  CPU address
- dma_cpu_data_in  input  8  CPU write data (page number)
- dma_halt_out  output  1  CPU halt/RDY low request; high while the DMA owns the bus
- dma_read_out  output  1  bus read strobe (to ram_controller read)
- dma_write_out  output  1  bus write strobe
- dma_address_out  output  16  bus address while halted
- dma_data_in  input  8  bus read data; registered responder, valid 1 cycle after the read strobe
- dma_data_out  output  8  bus write data
- debug_out  output  16  debug word (see Optional Feature)

Behaviour:
- Reset state:
  - All outputs 0, state IDLE.
  - Page register 0, byte index 0.
  - Parity bit 0; it toggles every clock thereafter. "Get" cycles are those with parity = 0.
- Trigger: in IDLE, dma_cpu_write_in=1 with dma_cpu_address_in==DMA_REG_ADDR on edge T:
  - page <= dma_cpu_data_in, index <= 0, state <= HALT.
  - Any other address does not trigger.
- States (registered outputs; values are those held during the state):
  - IDLE: halt=0, read=0, write=0, address=0, data_out=0.
  - HALT (1 cycle, dummy): halt=1, no strobes. Next state is READ if the parity in this cycle is 1, otherwise ALIGN.
  - ALIGN (1 cycle, dummy): halt=1, no strobes, next READ. Guarantees every READ lands on parity 0.
  - READ: halt=1, read=1, address={page, index[7:0]}, next WRITE.
  - WRITE: halt=1, write=1, address=OAM_DATA_ADDR, data_out=dma_data_in (sampled combinationally this cycle, the RAM's 1-cycle read latency). Then:
    - If index==XFER_COUNT-1: next IDLE.
    - Otherwise: index+1, next READ.
- Latency and counts:
  - Halt asserts the cycle after the trigger edge.
  - Total halt cycles: 513 (no ALIGN) or 514 (with ALIGN).
  - Halt drops the cycle after the last WRITE.
- Boundaries:
  - Index is 8 bits and never wraps into the next page. Page $FF ends at $FFFF with no access to $0000.
  - Trigger writes while not IDLE are ignored; page is unchanged and no retrigger occurs.
  - Reset mid-transfer: next cycle IDLE with all outputs 0; the transfer is abandoned and no further strobes are issued.
  - Trigger and reset in the same cycle: reset wins.
- Strobes: read and write are never both high; neither is high outside halt=1.

Optional Feature:
- Macro: OAM_DMA_DEBUG_EN.
- Defined: debug_out = {state[2:0], parity, 4'b0, index[7:0]}, registered, reset 0.
- Undefined: debug_out tied to 16'h0000, and the debug register is not synthesized.

Test Plan:
1. Reset, then write $02 to $4014 on a parity-1 edge (HALT lands on parity 0):
   - 514 halt cycles.
   - First read at $0200.
   - Preload RAM[$0200]=$A5; first write is $2004 with data $A5.
   - 256 reads and 256 writes; last read at $02FF.
2. Same trigger shifted one cycle (HALT on parity 1):
   - No ALIGN; exactly 513 halt cycles.
   - Every READ on parity 0.
3. Page $FF:
   - Reads $FF00..$FFFF in order, then IDLE.
   - No access to $0000; halt low on the following cycle.
4. Second write of $05 to $4014 at byte index 10 of a page-$03 transfer:
   - Transfer continues reading $030B..$03FF.
   - No restart; halt count is unchanged.
5. Assert dma_reset_in during the WRITE of index 100:
   - Next cycle halt/read/write=0, address=0, state IDLE.
   - A fresh $4014 write afterwards starts at index 0.
6. Write $07 to $4015 and read $4014:
   - No halt and no strobes.
   - debug_out stays 0 when OAM_DMA_DEBUG_EN is undefined; shows state IDLE when defined.
